alu_writeback_sequencer: RTL and testbench
==========================================

# alu_writeback_sequencer

Multi-cycle R-type execution sequencer that drives the 32x32 two-read/one-write register file. It accepts one operation at a time over a valid/ready handshake and drives both read addresses. It captures the operands from the register file's combinational read ports, computes the ALU result, and then issues a single-cycle write back to the register file. It sits directly upstream of the register file's write port and directly downstream of its read ports.

## Interface
- WIDTH, 32, data width; must match the register file.
- AWIDTH, 5, register address width (32 registers).
- Clk  in  1  clock; all state updates on the positive edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operation request.
- InReady  out  1  sequencer can accept an operation this cycle.
- Op  in  3  opcode.
- Rs  in  AWIDTH  source register A.
- Rt  in  AWIDTH  source register B.
- Rd  in  AWIDTH  destination register.
- ReadRegister1  out  AWIDTH  drives register file read port 1; carries latched Rs.
- ReadRegister2  out  AWIDTH  drives register file read port 2; carries latched Rt.
- ReadData1  in  WIDTH  register file read port 1 data, combinational.
- ReadData2  in  WIDTH  register file read port 2 data, combinational.
- WriteRegister  out  AWIDTH  latched Rd.
- WriteData  out  WIDTH  latched result.
- RegWrite  out  1  register file write enable.
- Done  out  1  one-cycle pulse when the operation retires.

## Operation
- FSM states and transitions:
  - IDLE: go to READ on accept (InValid && InReady at the edge).
  - READ: go to EXEC.
  - EXEC: go to WRITE.
  - WRITE: go to IDLE.
- Accept latches Op, Rs, Rt and Rd into internal registers. Input changes after accept have no effect.
- InReady = (state==IDLE) && !Reset.
- While InReady=0, InValid is ignored; upstream holds its request until accepted.
- READ: ReadRegister1/2 hold the latched Rs/Rt. ReadData1/2 are captured into operand registers A/B at the end of the cycle.
- EXEC: result register = f(Op, A, B).
- Opcodes:
  - 000 ADD (A+B)
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed, result 0 or 1)
  - 110 SLTU (unsigned)
  - 111 NOP
- Arithmetic wraps modulo 2^WIDTH; there is no overflow flag.
- WRITE: RegWrite = !Reset && Op!=NOP && Rd!=0. WriteRegister and WriteData are stable for the whole cycle. Done=1 for exactly this cycle, including NOP and Rd=0 cases.
- RegWrite is 0 in every state other than WRITE.
- Writes to register 0 are suppressed here, independent of the register file's zero handling.

## Timing
- Accept edge = edge 0.
- READ occupies the cycle after edge 0; EXEC the next; WRITE the next. The register file write happens at edge 3.
- InReady returns high in the cycle after edge 3, so the peak rate is one operation per 4 cycles.
- No hazards: a following operation's READ cycle starts no earlier than one cycle after edge 3, so it always sees the prior write.
- Reset values: state=IDLE, InReady=0 while Reset is high and 1 on the first cycle after Reset deasserts. All other outputs are 0: ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Done.
- Reset mid-operation, any state: the operation is abandoned and no register file write occurs. RegWrite is gated combinationally by Reset, so a WRITE-cycle reset also blocks the write.
- Reset and InValid in the same cycle: no accept.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD … OP_NOP)
  - state encoding (S_IDLE, S_READ, S_EXEC, S_WRITE)
  - default widths
- Sub-module seq_alu is purely combinational: Op, A, B in; result out.
- The FSM, latches and handshake live in the top module.

## Test plan
In all scenarios the bench preloads the register file by driving its write port directly while the sequencer is idle: r2=15, r3=27, r5=0xFFFFFFFF.
- ADD Rs=2 Rt=3 Rd=4 -> RegWrite=1 only in the cycle ending at edge 3, WriteRegister=4, WriteData=42, Done pulses once; r4 then reads 42.
- SUB 3,2 -> r8=12; SUB 2,3 -> r9=0xFFFFFFF4 (wrap).
- SLT 5,2 -> r10=1; SLTU 5,2 -> r11=0; XOR 2,3 -> r12=20.
- ADD with Rd=0 -> RegWrite never high, Done pulses, r0 reads 0. NOP with Rd=6 -> RegWrite never high, r6 unchanged.
- InValid held high for two operations, ADD 2,3->4 then ADD 4,4->7 -> accepts exactly 4 cycles apart, r7=84. InReady is low for the 3 cycles between accepts.
- Reset pulsed during EXEC of ADD 2,3->13 -> RegWrite stays 0, r13 unchanged, InReady=1 on the cycle after Reset deasserts. Reset pulsed during the WRITE cycle gives the same result.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU write-back sequencer: default widths,
// opcode values and the FSM state encoding.
package alu_seq_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_AWIDTH = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU used by the sequencer's EXEC step. Arithmetic wraps
// modulo 2^WIDTH; set-less-than variants return 0 or 1.
module seq_alu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    // Select the operation result for the current opcode.
    always_comb begin
        // NOTE: assign a default before the case so every path drives result and no latch is inferred.
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;  // OP_NOP produces nothing and is never written
        endcase
    end

endmodule

// File: rtl/alu_writeback_sequencer.sv
// Four-cycle R-type sequencer: accept -> READ (drive register file read
// ports, capture operands) -> EXEC (compute result) -> WRITE (one-cycle
// write-back strobe and Done pulse) -> IDLE.
module alu_writeback_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        Op,
    input  logic [AWIDTH-1:0] Rs,
    input  logic [AWIDTH-1:0] Rt,
    input  logic [AWIDTH-1:0] Rd,
    output logic [AWIDTH-1:0] ReadRegister1,
    output logic [AWIDTH-1:0] ReadRegister2,
    input  logic [WIDTH-1:0]  ReadData1,
    input  logic [WIDTH-1:0]  ReadData2,
    output logic [AWIDTH-1:0] WriteRegister,
    output logic [WIDTH-1:0]  WriteData,
    output logic              RegWrite,
    output logic              Done
);

    state_t            state;
    logic [2:0]        op_q;
    logic [AWIDTH-1:0] rs_q;
    logic [AWIDTH-1:0] rt_q;
    logic [AWIDTH-1:0] rd_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  alu_result;

    seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // FSM plus operation, operand and result registers; reset abandons any operation in flight.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // InReady is exactly "IDLE and not in reset", so InValid alone completes the handshake here.
                    if (InValid) begin
                        op_q  <= Op;
                        rs_q  <= Rs;
                        rt_q  <= Rt;
                        rd_q  <= Rd;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    a_q   <= ReadData1;
                    b_q   <= ReadData2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result_q <= alu_result;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ReadRegister1 = rs_q;
    assign ReadRegister2 = rt_q;
    assign WriteRegister = rd_q;
    assign WriteData     = result_q;

    // Reset gates the handshake and strobes directly so a reset in the WRITE cycle blocks the write.
    assign InReady  = (state == S_IDLE) && !Reset;
    assign Done     = (state == S_WRITE) && !Reset;
    assign RegWrite = (state == S_WRITE) && !Reset && (op_q != OP_NOP) && (rd_q != '0);

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// Bench for alu_writeback_sequencer: a bench-side register file, a
// transaction-level reference model checked every cycle, and directed
// operations with hand-computed literal results.
module tb_alu_writeback_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [4:0]  Rs = 5'd0;
    logic [4:0]  Rt = 5'd0;
    logic [4:0]  Rd = 5'd0;
    logic        InReady;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        Done;

    // bench-driven preload port of the register file
    logic        pl_we = 1'b0;
    logic [4:0]  pl_wa = 5'd0;
    logic [31:0] pl_wd = 32'd0;

    logic [31:0] rf     [32] = '{default: 32'd0};
    logic [31:0] exp_rf [32] = '{default: 32'd0};

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int dut_acc[$];

    // transaction-level model: phase counts cycles since accept (0 = idle)
    int          m_phase = 0;
    logic [2:0]  m_op = 3'd0;
    logic [4:0]  m_rs = 5'd0;
    logic [4:0]  m_rt = 5'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;

    alu_writeback_sequencer #(
        .WIDTH  (32),
        .AWIDTH (5)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InValid       (InValid),
        .InReady       (InReady),
        .Op            (Op),
        .Rs            (Rs),
        .Rt            (Rt),
        .Rd            (Rd),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .Done          (Done)
    );

    always #5 Clk = ~Clk;

    assign ReadData1 = rf[ReadRegister1];
    assign ReadData2 = rf[ReadRegister2];

    always @(posedge Clk) begin
        if (RegWrite)   rf[WriteRegister] <= WriteData;
        else if (pl_we) rf[pl_wa] <= pl_wd;
    end

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model update at each active edge.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (pl_we) exp_rf[pl_wa] <= pl_wd;
        if (Reset) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (InValid) begin
                    m_op <= Op; m_rs <= Rs; m_rt <= Rt; m_rd <= Rd;
                    m_phase <= 1;
                end
                1: begin
                    m_a <= exp_rf[m_rs];
                    m_b <= exp_rf[m_rt];
                    m_phase <= 2;
                end
                2: m_phase <= 3;
                default: begin
                    if (m_op != 3'd7 && m_rd != 5'd0) exp_rf[m_rd] <= alu_model(m_op, m_a, m_b);
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge Clk) begin
        if (cyc > 0) begin
            if (InValid && InReady) dut_acc.push_back(cyc);
            check("InReady", 32'(InReady), 32'(m_phase == 0 && !Reset));
            check("Done", 32'(Done), 32'(m_phase == 3 && !Reset));
            check("RegWrite", 32'(RegWrite), 32'(m_phase == 3 && !Reset && m_op != 3'd7 && m_rd != 5'd0));
            if (m_phase == 1 && !Reset) begin
                check("ReadRegister1", 32'(ReadRegister1), 32'(m_rs));
                check("ReadRegister2", 32'(ReadRegister2), 32'(m_rt));
            end
            if (m_phase == 3 && !Reset) begin
                check("WriteRegister", 32'(WriteRegister), 32'(m_rd));
                check("WriteData", WriteData, alu_model(m_op, m_a, m_b));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(posedge Clk); #1;
        pl_we = 1'b1; pl_wa = a; pl_wd = d;
        @(posedge Clk); #1;
        pl_we = 1'b0;
    endtask

    // Waits (bounded) at negedges until InReady is high; the next edge accepts.
    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge Clk);
            if (InReady) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          output logic [31:0] wd, output logic [4:0] wr, output int regw_cnt);
        bit seen = 1'b0;
        wd = 32'd0; wr = 5'd0; regw_cnt = 0;
        @(posedge Clk); #1;
        InValid = 1'b1; Op = op; Rs = rs; Rt = rt; Rd = rd;
        wait_ready("accept_timeout");
        @(posedge Clk); #1;
        // scramble fields after accept; the latched operation must be unaffected
        InValid = 1'b0; Op = 3'($urandom); Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom);
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge Clk);
            if (RegWrite) regw_cnt++;
            if (Done) begin
                seen = 1'b1; wd = WriteData; wr = WriteRegister;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd;
        logic [4:0]  wr;
        int          rw;

        // reset with a request pending: nothing may be accepted
        Reset = 1'b1;
        InValid = 1'b1; Op = 3'd0; Rs = 5'd2; Rt = 5'd3; Rd = 5'd4;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0; InValid = 1'b0;
        @(negedge Clk);
        check("rst_InReady", 32'(InReady), 32'd1);
        check("rst_ReadRegister1", 32'(ReadRegister1), 32'd0);
        check("rst_ReadRegister2", 32'(ReadRegister2), 32'd0);
        check("rst_WriteRegister", 32'(WriteRegister), 32'd0);
        check("rst_WriteData", WriteData, 32'd0);
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_Done", 32'(Done), 32'd0);

        preload(5'd2, 32'd15);
        preload(5'd3, 32'd27);
        preload(5'd5, 32'hFFFF_FFFF);
        preload(5'd6, 32'h0000_0066);

        run_op(3'd0, 5'd2, 5'd3, 5'd4, wd, wr, rw);
        check("add_WriteData", wd, 32'd42);
        check("add_WriteRegister", 32'(wr), 32'd4);
        check("add_regwrite_cycles", 32'(rw), 32'd1);
        idle(1);
        check("r4_add", rf[4], 32'd42);

        run_op(3'd1, 5'd3, 5'd2, 5'd8,  wd, wr, rw);
        run_op(3'd1, 5'd2, 5'd3, 5'd9,  wd, wr, rw);
        run_op(3'd5, 5'd5, 5'd2, 5'd10, wd, wr, rw);
        run_op(3'd6, 5'd5, 5'd2, 5'd11, wd, wr, rw);
        run_op(3'd4, 5'd2, 5'd3, 5'd12, wd, wr, rw);
        run_op(3'd2, 5'd2, 5'd3, 5'd14, wd, wr, rw);
        run_op(3'd3, 5'd2, 5'd3, 5'd15, wd, wr, rw);
        idle(1);
        check("r8_sub", rf[8], 32'd12);
        check("r9_sub_wrap", rf[9], 32'hFFFF_FFF4);
        check("r10_slt", rf[10], 32'd1);
        check("r11_sltu", rf[11], 32'd0);
        check("r12_xor", rf[12], 32'd20);
        check("r14_and", rf[14], 32'd11);
        check("r15_or", rf[15], 32'd31);

        run_op(3'd0, 5'd2, 5'd3, 5'd0, wd, wr, rw);
        check("rd0_regwrite_cycles", 32'(rw), 32'd0);
        run_op(3'd7, 5'd2, 5'd3, 5'd6, wd, wr, rw);
        check("nop_regwrite_cycles", 32'(rw), 32'd0);
        idle(1);
        check("r0_unwritten", rf[0], 32'd0);
        check("r6_unchanged", rf[6], 32'h0000_0066);

        // back-to-back with InValid held high
        dut_acc.delete();
        @(posedge Clk); #1;
        InValid = 1'b1; Op = 3'd0; Rs = 5'd2; Rt = 5'd3; Rd = 5'd4;
        wait_ready("b2b_first_timeout");
        @(posedge Clk); #1;
        Rs = 5'd4; Rt = 5'd4; Rd = 5'd7;
        wait_ready("b2b_second_timeout");
        @(posedge Clk); #1;
        InValid = 1'b0;
        idle(5);
        check("b2b_accept_count", 32'(dut_acc.size()), 32'd2);
        if (dut_acc.size() == 2) check("b2b_accept_spacing", 32'(dut_acc[1] - dut_acc[0]), 32'd4);
        check("r7_b2b", rf[7], 32'd84);

        // reset during EXEC
        @(posedge Clk); #1;
        InValid = 1'b1; Op = 3'd0; Rs = 5'd2; Rt = 5'd3; Rd = 5'd13;
        wait_ready("rst_exec_accept_timeout");
        @(posedge Clk); #1;          // READ
        InValid = 1'b0;
        @(posedge Clk); #1;          // EXEC
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_exec_InReady", 32'(InReady), 32'd1);
        idle(5);
        check("r13_rst_exec", rf[13], 32'd0);

        // reset during WRITE
        @(posedge Clk); #1;
        InValid = 1'b1; Op = 3'd0; Rs = 5'd2; Rt = 5'd3; Rd = 5'd13;
        wait_ready("rst_write_accept_timeout");
        @(posedge Clk); #1;          // READ
        InValid = 1'b0;
        @(posedge Clk); #1;          // EXEC
        @(posedge Clk); #1;          // WRITE
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_write_RegWrite", 32'(RegWrite), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_write_InReady", 32'(InReady), 32'd1);
        idle(5);
        check("r13_rst_write", rf[13], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
